// File: rtl/axppa_pkg.sv
// Shared types and default sizes for the approximate-adder error monitor.
package axppa_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/axppa_err_dist.sv
// Exact WIDTH+1-bit sum of two operands and its unsigned distance to an approximate result.
module axppa_err_dist #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   apx,
  output logic [WIDTH:0]   exact,
  output logic [WIDTH:0]   ed
);

  assign exact = {1'b0, a} + {1'b0, b};
  // Both operands are unsigned, so over- and under-estimation give the same distance.
  assign ed    = (exact >= apx) ? (exact - apx) : (apx - exact);

endmodule

// File: rtl/axppa_err_monitor.sv
// Error monitor for an approximate adder: counts erroneous samples and accumulates error distance.
// Optional max_ed tracking is enabled by defining AXPPA_MAXED_EN.
module axppa_err_monitor
  import axppa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       sample_count,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic [WIDTH:0]         in_sum_apx,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       err_count,
  output logic [WIDTH+CNT_W:0]   ed_sum
`ifdef AXPPA_MAXED_EN
  ,
  output logic [WIDTH:0]         max_ed
`endif
);

  // Handshake: a sample transfers on every rising edge where in_valid and in_ready
  // are both high; in_ready depends only on the registered state, never on in_valid.

  state_t             state;
  logic [CNT_W-1:0]   target;
  logic [CNT_W-1:0]   accepted;
  logic               s1_valid;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic [WIDTH:0]     s1_apx;
  logic [WIDTH:0]     exact;
  logic [WIDTH:0]     ed;
  logic               accept;
  logic               last;

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  assign accept   = in_valid && in_ready;
  assign last     = (accepted == target - 1'b1);

  // Stage 2 datapath: exact sum and distance of the registered sample.
  axppa_err_dist #(.WIDTH(WIDTH)) u_err_dist (
    .a     (s1_a),
    .b     (s1_b),
    .apx   (s1_apx),
    .exact (exact),
    .ed    (ed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      target    <= '0;
      accepted  <= '0;
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_apx    <= '0;
      err_count <= '0;
      ed_sum    <= '0;
`ifdef AXPPA_MAXED_EN
      max_ed    <= '0;
`endif
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_apx   <= in_sum_apx;
        accepted <= accepted + 1'b1;
      end

      if (s1_valid) begin
        if (exact != s1_apx) err_count <= err_count + 1'b1;
        ed_sum <= ed_sum + {{CNT_W{1'b0}}, ed};
`ifdef AXPPA_MAXED_EN
        if (ed > max_ed) max_ed <= ed;
`endif
      end

      case (state)
        IDLE, DONE: begin
          // The pipeline is empty here, so clearing cannot lose an in-flight sample.
          if (start) begin
            target    <= sample_count;
            accepted  <= '0;
            err_count <= '0;
            ed_sum    <= '0;
`ifdef AXPPA_MAXED_EN
            max_ed    <= '0;
`endif
            state     <= (sample_count != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (accept && last) state <= DRAIN;
        end
        DRAIN: begin
          if (!s1_valid) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
